// File: rtl/regfile_wport_arb.sv
// Round-robin arbiter that shares the register file's single write port between two writeback sources.
// Optional macro RFARB_BYPASS_EN forwards the in-flight write data onto the read ports.
module regfile_wport_arb #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,
    input  logic            wr_inhibit,
    output logic            we3,
    output logic [AW-1:0]   wa3,
    output logic [DW-1:0]   wd3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [DW-1:0]   rd1_in,
    input  logic [DW-1:0]   rd2_in,
    output logic [DW-1:0]   rd1_out,
    output logic [DW-1:0]   rd2_out,
    output logic            pend1,
    output logic            pend2,
    output logic [CNTW-1:0] conflict_cnt
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e last_grant;
    logic   grant_a;
    logic   grant_b;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset_n && !wr_inhibit) begin
            if (a_valid && b_valid) begin
                grant_a = (last_grant == GRANT_B);
                grant_b = (last_grant == GRANT_A);
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we3          <= 1'b0;
            wa3          <= '0;
            wd3          <= '0;
            last_grant   <= GRANT_B;
            conflict_cnt <= '0;
        end else begin
            if (grant_a) begin
                we3        <= (a_addr != '0);
                wa3        <= a_addr;
                wd3        <= a_data;
                last_grant <= GRANT_A;
            end else if (grant_b) begin
                we3        <= (b_addr != '0);
                wa3        <= b_addr;
                wd3        <= b_data;
                last_grant <= GRANT_B;
            end else begin
                we3 <= 1'b0;
            end

            // Counts contention even while inhibited; sticks at all-ones.
            if (a_valid && b_valid && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + CNTW'(1);
        end
    end

    // r0 is hardwired, so a read of r0 never hits the in-flight write.
    assign pend1 = we3 && (ra1 == wa3) && (ra1 != '0);
    assign pend2 = we3 && (ra2 == wa3) && (ra2 != '0);

`ifdef RFARB_BYPASS_EN
    assign rd1_out = pend1 ? wd3 : rd1_in;
    assign rd2_out = pend2 ? wd3 : rd2_in;
`else
    assign rd1_out = rd1_in;
    assign rd2_out = rd2_in;
`endif

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed bench for regfile_wport_arb: reset, single writes, round-robin ties, r0 drop,
// inhibit, read-hit flags/bypass and conflict counter saturation (counter width shrunk to 4).
module tb_regfile_wport_arb;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            a_valid, b_valid, wr_inhibit;
    logic            a_ready, b_ready;
    logic [AW-1:0]   a_addr, b_addr, ra1, ra2;
    logic [DW-1:0]   a_data, b_data, rd1_in, rd2_in;
    logic            we3, pend1, pend2;
    logic [AW-1:0]   wa3;
    logic [DW-1:0]   wd3, rd1_out, rd2_out;
    logic [CNTW-1:0] conflict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_wport_arb #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_inhibit(wr_inhibit),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1_in(rd1_in), .rd2_in(rd2_in),
        .rd1_out(rd1_out), .rd2_out(rd2_out),
        .pend1(pend1), .pend2(pend2),
        .conflict_cnt(conflict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; wr_inhibit = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        b_valid = 1'b0; b_addr = '0;   b_data = '0;
        ra1 = '0; ra2 = '0; rd1_in = '0; rd2_in = '0;

        // Reset held two edges with A pending: nothing granted, state cleared
        @(negedge clk);
        check("rst_a_ready_c1", a_ready, 0);
        next();
        @(negedge clk);
        check("rst_a_ready_c2", a_ready, 0);
        check("rst_we3", we3, 0);
        check("rst_wa3", wa3, 0);
        check("rst_cnt", conflict_cnt, 0);
        next();

        // Release: A accepted immediately, write appears one cycle later
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_a_ready", a_ready, 1);
        check("rel_b_ready", b_ready, 0);
        next();
        a_valid = 1'b0;
        @(negedge clk);
        check("a_we3", we3, 1);
        check("a_wa3", wa3, 5);
        check("a_wd3", wd3, 32'hDEADBEEF);
        next();
        @(negedge clk);
        check("a_we3_drop", we3, 0);
        check("a_wa3_hold", wa3, 5);
        check("a_wd3_hold", wd3, 32'hDEADBEEF);

        // Re-reset so last_grant=B and the counter restarts
        reset_n = 1'b0;
        next();
        reset_n = 1'b1;

        // Tie for four cycles: A,B,A,B
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
        @(negedge clk);
        check("tie1_a_ready", a_ready, 1);
        check("tie1_b_ready", b_ready, 0);
        next();
        @(negedge clk);
        check("tie2_a_ready", a_ready, 0);
        check("tie2_b_ready", b_ready, 1);
        check("tie2_wa3", wa3, 3);
        check("tie2_wd3", wd3, 32'h11);
        next();
        @(negedge clk);
        check("tie3_a_ready", a_ready, 1);
        check("tie3_wa3", wa3, 4);
        check("tie3_wd3", wd3, 32'h22);
        next();
        @(negedge clk);
        check("tie4_b_ready", b_ready, 1);
        check("tie4_wa3", wa3, 3);
        next();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("tie_last_wa3", wa3, 4);
        check("tie_we3", we3, 1);
        check("tie_cnt", conflict_cnt, 4);
        next();

        // Write to r0: accepted, never enabled, still counts as B's turn
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        @(negedge clk);
        check("r0_b_ready", b_ready, 1);
        next();
        b_valid = 1'b0;
        @(negedge clk);
        check("r0_we3", we3, 0);
        check("r0_wa3", wa3, 0);
        check("r0_wd3", wd3, 32'hFFFFFFFF);
        next();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
        @(negedge clk);
        check("r0_tie_a_ready", a_ready, 1);
        check("r0_tie_b_ready", b_ready, 0);
        next();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("r0_tie_cnt", conflict_cnt, 5);

        // Inhibit: in-flight r7 write completes, B waits
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7;
        @(negedge clk);
        check("inh_a_ready", a_ready, 1);
        next();
        a_valid = 1'b0; wr_inhibit = 1'b1;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
        @(negedge clk);
        check("inh_we3", we3, 1);
        check("inh_wa3", wa3, 7);
        check("inh_wd3", wd3, 32'h7);
        check("inh_b_ready", b_ready, 0);
        next();
        @(negedge clk);
        check("inh2_we3", we3, 0);
        check("inh2_b_ready", b_ready, 0);
        next();
        wr_inhibit = 1'b0;
        @(negedge clk);
        check("uninh_b_ready", b_ready, 1);
        next();
        b_valid = 1'b0;
        @(negedge clk);
        check("uninh_we3", we3, 1);
        check("uninh_wa3", wa3, 8);
        check("uninh_wd3", wd3, 32'h88);

        // Read hit on the in-flight write to r9
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hCAFE0000;
        next();
        a_valid = 1'b0;
        ra1 = 5'd9; rd1_in = 32'h0;
        ra2 = 5'd0; rd2_in = 32'h1234;
        @(negedge clk);
        check("byp_pend1", pend1, 1);
        check("byp_pend2", pend2, 0);
`ifdef RFARB_BYPASS_EN
        check("byp_rd1_out", rd1_out, 32'hCAFE0000);
`else
        check("byp_rd1_out", rd1_out, 32'h0);
`endif
        check("byp_rd2_out", rd2_out, 32'h1234);
        ra2 = 5'd9; rd2_in = 32'h5555;
        @(posedge clk);
        #0;
        #1;
        // The r9 write has retired, so the hit has cleared
        check("byp_retired_pend1", pend1, 0);
        check("byp_retired_rd1", rd1_out, 32'h0);

        // r0 target with r0 read: never pending
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h5;
        next();
        b_valid = 1'b0; ra2 = 5'd0;
        @(negedge clk);
        check("r0_rd_wa3", wa3, 0);
        check("r0_rd_pend2", pend2, 0);

        // Counter saturation (CNTW=4): contention under inhibit still counts, stops at 15
        wr_inhibit = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 10; i++) next();
        @(negedge clk);
        check("sat_cnt_max", conflict_cnt, 15);
        check("sat_a_ready", a_ready, 0);
        check("sat_b_ready", b_ready, 0);
        for (int i = 0; i < 5; i++) next();
        @(negedge clk);
        check("sat_cnt_hold", conflict_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
